// File: rtl/hazard_stage_tracker.sv
// Tracks destination registers of EX/MEM/WB instructions for forwarding, detects load-use
// hazards at ID (one EX bubble, IF/ID held), freezes on mem_stall, squashes EX on flush.
// Optional build macro: REGFILE_BYPASS_EN keeps the WB stage register and drives wb_rd_addr.
module hazard_stage_tracker #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
    input  logic                      id_reg_write,
    input  logic                      id_is_load,
    input  logic                      flush,
    input  logic                      mem_stall,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    output logic [REG_ADDR_WIDTH-1:0] mem_rd_addr,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
    output logic                      ex_is_load,
    output logic                      stall_if_id,
    output logic                      bubble_ex,
    output logic [CNT_WIDTH-1:0]      stall_count
);

    localparam logic [REG_ADDR_WIDTH-1:0] RD_NONE = '0;
    localparam logic [CNT_WIDTH-1:0]      CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0]      CNT_ONE = 1;

    logic [REG_ADDR_WIDTH-1:0] r_ex_rd;
    logic [REG_ADDR_WIDTH-1:0] r_mem_rd;
    logic                      r_ex_is_load;
    logic [CNT_WIDTH-1:0]      r_stall_count;

    logic [REG_ADDR_WIDTH-1:0] w_id_rd;
    logic                      w_id_is_load;
    logic                      w_load_use;
    logic                      w_stall;
    logic                      w_bubble;

    always_comb begin
        w_id_rd      = (id_valid && id_reg_write) ? id_rd_addr : RD_NONE;
        w_id_is_load = id_valid && id_is_load;
        w_load_use   = r_ex_is_load && (r_ex_rd != RD_NONE) && id_valid &&
                       ((id_rs1_addr == r_ex_rd) || (id_rs2_addr == r_ex_rd));
        // Priority rst > mem_stall > flush > load_use; flush drops a pending load-use stall.
        w_stall      = !rst && (mem_stall || (!flush && w_load_use));
        w_bubble     = !rst && !mem_stall && (flush || w_load_use);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_rd      <= RD_NONE;
            r_ex_is_load <= 1'b0;
            r_mem_rd     <= RD_NONE;
        end else if (!mem_stall) begin
            if (w_bubble) begin
                r_ex_rd      <= RD_NONE;
                r_ex_is_load <= 1'b0;
            end else begin
                r_ex_rd      <= w_id_rd;
                r_ex_is_load <= w_id_is_load;
            end
            r_mem_rd <= r_ex_rd;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic [REG_ADDR_WIDTH-1:0] r_wb_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_rd <= RD_NONE;
        end else if (!mem_stall) begin
            r_wb_rd <= r_mem_rd;
        end
    end

    assign wb_rd_addr = r_wb_rd;
`else
    assign wb_rd_addr = RD_NONE;
`endif

    // Saturating count of cycles in which IF/ID is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != CNT_MAX)) begin
            r_stall_count <= r_stall_count + CNT_ONE;
        end
    end

    assign ex_rd_addr  = r_ex_rd;
    assign mem_rd_addr = r_mem_rd;
    assign ex_is_load  = r_ex_is_load;
    assign stall_if_id = w_stall;
    assign bubble_ex   = w_bubble;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_stage_tracker.sv
// Table-driven bench for hazard_stage_tracker: per-cycle input/expected-output rows,
// plus a mem_stall-then-load-use sequence of random length; a CNT_WIDTH=2 twin checks saturation.
module tb_hazard_stage_tracker;

    typedef struct {
        logic       rst, v;
        logic [4:0] rs1, rs2, rd;
        logic       rw, ld, fl, ms;
        logic [4:0] e_ex, e_mem, e_wb;
        logic       e_ld, e_stall, e_bub;
        int         e_cnt;
    } vec_t;

    // {ex, mem, wb, ld, stall, bub, cnt16, sat2}
    localparam int EW = 5 + 5 + 5 + 3 + 16 + 2;

    logic clk = 1'b0;
    logic rst, id_valid, id_reg_write, id_is_load, flush, mem_stall;
    logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [4:0] ex_rd_addr, mem_rd_addr, wb_rd_addr;
    logic ex_is_load, stall_if_id, bubble_ex;
    logic [15:0] stall_count;
    logic [4:0] s_ex_rd, s_mem_rd, s_wb_rd;
    logic s_ex_is_load, s_stall, s_bubble;
    logic [1:0] s_count;

    vec_t vecs[$];
    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_stage_tracker #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1_addr(id_rs1_addr),
        .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .flush(flush), .mem_stall(mem_stall),
        .ex_rd_addr(ex_rd_addr), .mem_rd_addr(mem_rd_addr), .wb_rd_addr(wb_rd_addr),
        .ex_is_load(ex_is_load), .stall_if_id(stall_if_id), .bubble_ex(bubble_ex),
        .stall_count(stall_count)
    );

    hazard_stage_tracker #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1_addr(id_rs1_addr),
        .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .flush(flush), .mem_stall(mem_stall),
        .ex_rd_addr(s_ex_rd), .mem_rd_addr(s_mem_rd), .wb_rd_addr(s_wb_rd),
        .ex_is_load(s_ex_is_load), .stall_if_id(s_stall), .bubble_ex(s_bubble),
        .stall_count(s_count)
    );

    task automatic add_row(input logic r, input logic v, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd, input logic rw,
                           input logic ld, input logic fl, input logic ms,
                           input logic [4:0] e_ex, input logic [4:0] e_mem,
                           input logic [4:0] e_wb, input logic e_ld, input logic e_stall,
                           input logic e_bub, input int e_cnt);
        vec_t t;
        t.rst = r; t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
        t.rw = rw; t.ld = ld; t.fl = fl; t.ms = ms;
        t.e_ex = e_ex; t.e_mem = e_mem; t.e_wb = e_wb;
        t.e_ld = e_ld; t.e_stall = e_stall; t.e_bub = e_bub; t.e_cnt = e_cnt;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL row %0d %s: got %0h expected %0h", row, name, act, exp);
        end
    endtask

    initial begin
        int n_ms;
        logic [EW-1:0] e;
        logic [1:0] sat;
        logic [4:0] wb_exp;

        rst = 1'b1; id_valid = 1'b0; id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
        id_reg_write = 1'b0; id_is_load = 1'b0; flush = 1'b0; mem_stall = 1'b0;

        //       rst v rs1 rs2 rd rw ld fl ms | ex mem wb ld st bu cnt
        add_row(1, 1,  0,  0,  5, 1, 0, 0, 0,   0,  0,  0, 0, 0, 0, 0);
        add_row(1, 1,  0,  0,  5, 1, 0, 0, 1,   0,  0,  0, 0, 0, 0, 0);
        add_row(0, 1,  0,  0,  3, 1, 0, 0, 0,   0,  0,  0, 0, 0, 0, 0);
        add_row(0, 1,  0,  0,  4, 1, 0, 0, 0,   3,  0,  0, 0, 0, 0, 0);
        add_row(0, 0,  0,  0,  0, 0, 0, 0, 0,   4,  3,  0, 0, 0, 0, 0);
        add_row(0, 1,  0,  0,  7, 1, 1, 0, 0,   0,  4,  3, 0, 0, 0, 0);
        add_row(0, 1,  1,  7, 10, 1, 0, 0, 0,   7,  0,  4, 1, 1, 1, 0);
        add_row(0, 1,  1,  7, 10, 1, 0, 0, 0,   0,  7,  0, 0, 0, 0, 1);
        add_row(0, 1,  0,  0,  0, 1, 1, 0, 0,  10,  0,  7, 0, 0, 0, 1);
        add_row(0, 1,  0,  0,  7, 1, 1, 0, 0,   0, 10,  0, 1, 0, 0, 1);
        add_row(0, 1,  8,  8,  2, 1, 0, 0, 0,   7,  0, 10, 1, 0, 0, 1);
        add_row(0, 1,  0,  0,  9, 1, 1, 0, 0,   2,  7,  0, 0, 0, 0, 1);
        add_row(0, 1,  9,  0, 11, 1, 0, 0, 1,   9,  2,  7, 1, 1, 0, 1);
        add_row(0, 1,  9,  0, 11, 1, 0, 0, 1,   9,  2,  7, 1, 1, 0, 2);
        add_row(0, 1,  9,  0, 11, 1, 0, 0, 1,   9,  2,  7, 1, 1, 0, 3);
        add_row(0, 1,  9,  0, 11, 1, 0, 0, 0,   9,  2,  7, 1, 1, 1, 4);
        add_row(0, 1,  9,  0, 11, 1, 0, 0, 0,   0,  9,  2, 0, 0, 0, 5);
        add_row(0, 1,  0,  0,  6, 1, 1, 0, 0,  11,  0,  9, 0, 0, 0, 5);
        add_row(0, 1,  0,  6, 12, 1, 0, 1, 0,   6, 11,  0, 1, 0, 1, 5);
        add_row(0, 0,  0,  0,  0, 0, 0, 0, 0,   0,  6, 11, 0, 0, 0, 5);
        add_row(0, 1,  0,  0, 13, 1, 1, 0, 0,   0,  0,  6, 0, 0, 0, 5);
        add_row(0, 1, 13,  0, 14, 1, 0, 1, 1,  13,  0,  0, 1, 1, 0, 5);
        add_row(1, 1, 13,  0, 14, 1, 0, 0, 0,  13,  0,  0, 1, 0, 0, 6);
        add_row(0, 1, 13,  0, 14, 1, 0, 0, 0,   0,  0,  0, 0, 0, 0, 0);
        add_row(0, 0,  0,  0,  0, 0, 0, 0, 0,  14,  0,  0, 0, 0, 0, 0);
        add_row(0, 1,  0,  0, 15, 0, 0, 0, 0,   0, 14,  0, 0, 0, 0, 0);
        add_row(0, 0,  0,  0,  0, 0, 0, 0, 0,   0,  0, 14, 0, 0, 0, 0);

        // Random-length freeze on top of a load-use, then the single bubble.
        n_ms = $urandom_range(1, 4);
        add_row(0, 1,  0,  0, 20, 1, 1, 0, 0,   0,  0,  0, 0, 0, 0, 0);
        for (int i = 0; i < n_ms; i++)
            add_row(0, 1, 3, 20, 21, 1, 0, 0, 1, 20, 0, 0, 1, 1, 0, i);
        add_row(0, 1,  3, 20, 21, 1, 0, 0, 0,  20,  0,  0, 1, 1, 1, n_ms);
        add_row(0, 1,  3, 20, 21, 1, 0, 0, 0,   0, 20,  0, 0, 0, 0, n_ms + 1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; id_valid = vecs[i].v; id_rs1_addr = vecs[i].rs1;
            id_rs2_addr = vecs[i].rs2; id_rd_addr = vecs[i].rd; id_reg_write = vecs[i].rw;
            id_is_load = vecs[i].ld; flush = vecs[i].fl; mem_stall = vecs[i].ms;
            sat = (vecs[i].e_cnt > 3) ? 2'd3 : vecs[i].e_cnt[1:0];
`ifdef REGFILE_BYPASS_EN
            wb_exp = vecs[i].e_wb;
`else
            wb_exp = 5'd0;
`endif
            exp_q.push_back({vecs[i].e_ex, vecs[i].e_mem, wb_exp, vecs[i].e_ld,
                             vecs[i].e_stall, vecs[i].e_bub, vecs[i].e_cnt[15:0], sat});
            #2;
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", i, 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("ex_rd_addr",  i, {27'd0, ex_rd_addr},  {27'd0, e[35:31]});
                check("mem_rd_addr", i, {27'd0, mem_rd_addr}, {27'd0, e[30:26]});
                check("wb_rd_addr",  i, {27'd0, wb_rd_addr},  {27'd0, e[25:21]});
                check("ex_is_load",  i, {31'd0, ex_is_load},  {31'd0, e[20]});
                check("stall_if_id", i, {31'd0, stall_if_id}, {31'd0, e[19]});
                check("bubble_ex",   i, {31'd0, bubble_ex},   {31'd0, e[18]});
                check("stall_count", i, {16'd0, stall_count}, {16'd0, e[17:2]});
                check("sat_count",   i, {30'd0, s_count},     {30'd0, e[1:0]});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
